// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: mode encoding and a counter-width helper.
package run_ctrl_pkg;

   // Encodings are visible on the mode port.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SEED  = 2'b01,
      RUN   = 2'b10,
      PAUSE = 2'b11
   } mode_t;

   // Width of a counter holding 0..n-1; never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-N divider: counts enabled cycles 0..N-1 and flags the last one.
module tick_divider
   import run_ctrl_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic wrap
);

   localparam int unsigned W    = cnt_width(N);
   localparam logic [W-1:0] Last = W'(N - 1);

   logic [W-1:0] cnt_q;

   // wrap is combinational so the owner can strobe in the same cycle.
   assign wrap = (cnt_q == Last);

   // Count enabled cycles; clr restarts the phase.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: IDLE -> SEED (fixed length) -> RUN <-> PAUSE, with a generation tick
// and a saturating generation counter.
// Optional feature: define RUN_CTRL_SINGLE_STEP_EN to add the step port, which issues
// one tick per request while paused.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int unsigned GEN_W       = 16,
   parameter int unsigned TICK_DIV    = 4,
   parameter int unsigned SEED_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   input  logic             lfsr,
`ifdef RUN_CTRL_SINGLE_STEP_EN
   input  logic             step,
`endif
   output logic [1:0]       mode,
   output logic             seed_en,
   output logic             seed_bit,
   output logic             tick,
   output logic [GEN_W-1:0] gen_count,
   output logic             busy
);

   localparam int unsigned   SW       = cnt_width(SEED_CYCLES);
   localparam logic [SW-1:0] SeedLast = SW'(SEED_CYCLES - 1);

   mode_t             mode_q;
   logic [SW-1:0]     seed_cnt_q;
   logic [GEN_W-1:0]  gen_q;
   logic              div_wrap;
   logic              step_tick;
   logic              tick_int;

   // Divider is held at zero throughout SEED so RUN always starts a fresh period.
   tick_divider #(
      .N (TICK_DIV)
   ) u_div (
      .clk   (clk),
      .reset (reset),
      .clr   (mode_q == SEED),
      .en    (mode_q == RUN),
      .wrap  (div_wrap)
   );

`ifdef RUN_CTRL_SINGLE_STEP_EN
   // A simultaneous start restarts seeding, so it suppresses the step.
   assign step_tick = (mode_q == PAUSE) && step && !start;
`else
   assign step_tick = 1'b0;
`endif

   assign tick_int = ((mode_q == RUN) && div_wrap) || step_tick;

   // Outputs read as idle for the whole time reset is held, even before the first edge.
   always_comb begin
      mode      = reset ? IDLE : mode_q;
      busy      = !reset && (mode_q != IDLE);
      seed_en   = !reset && (mode_q == SEED);
      seed_bit  = seed_en && lfsr;
      tick      = !reset && tick_int;
      gen_count = gen_q;
   end

   // Mode FSM plus seed and generation counters; entering SEED clears both counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q     <= IDLE;
         seed_cnt_q <= '0;
         gen_q      <= '0;
      end else begin
         if (tick_int && (gen_q != '1)) begin
            gen_q <= gen_q + 1'b1;
         end
         unique case (mode_q)
            IDLE: begin
               if (start) begin
                  mode_q     <= SEED;
                  seed_cnt_q <= '0;
                  gen_q      <= '0;
               end
            end
            SEED: begin
               if (seed_cnt_q == SeedLast) begin
                  mode_q <= RUN;
               end else begin
                  seed_cnt_q <= seed_cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (start) begin
                  mode_q     <= SEED;
                  seed_cnt_q <= '0;
                  gen_q      <= '0;
               end else if (pause) begin
                  mode_q <= PAUSE;
               end
            end
            PAUSE: begin
               if (start) begin
                  mode_q     <= SEED;
                  seed_cnt_q <= '0;
                  gen_q      <= '0;
               end else if (!pause) begin
                  mode_q <= RUN;
               end
            end
            default: mode_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: a cycle model pushes expected outputs into a
// scoreboard when stimulus is driven; a monitor pops and compares them each cycle.
// Two instances share stimulus: 16-bit and 2-bit generation counters.
module tb_run_ctrl;
   import run_ctrl_pkg::*;

   localparam int SC = 8;
   localparam int TD = 4;
`ifdef RUN_CTRL_SINGLE_STEP_EN
   localparam bit StepEn = 1'b1;
`else
   localparam bit StepEn = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]  mode;
      logic        seed_en;
      logic        seed_bit;
      logic        tick;
      logic        busy;
      logic [31:0] gen;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, start, pause, lfsr, step;
   logic [1:0]  mode_a, mode_b;
   logic        seed_en_a, seed_en_b, seed_bit_a, seed_bit_b, tick_a, tick_b, busy_a, busy_b;
   logic [15:0] gen_a;
   logic [1:0]  gen_b;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_seed_en = 0;
   int   n_tick    = 0;
   exp_t sb_q[$];

   mode_t m_mode;
   int    m_seed, m_div, m_gen;

   always #5 clk = ~clk;

   run_ctrl #(.GEN_W(16), .TICK_DIV(TD), .SEED_CYCLES(SC)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .pause     (pause),
      .lfsr      (lfsr),
`ifdef RUN_CTRL_SINGLE_STEP_EN
      .step      (step),
`endif
      .mode      (mode_a),
      .seed_en   (seed_en_a),
      .seed_bit  (seed_bit_a),
      .tick      (tick_a),
      .gen_count (gen_a),
      .busy      (busy_a)
   );

   run_ctrl #(.GEN_W(2), .TICK_DIV(TD), .SEED_CYCLES(SC)) u_sat (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .pause     (pause),
      .lfsr      (lfsr),
`ifdef RUN_CTRL_SINGLE_STEP_EN
      .step      (step),
`endif
      .mode      (mode_b),
      .seed_en   (seed_en_b),
      .seed_bit  (seed_bit_b),
      .tick      (tick_b),
      .gen_count (gen_b),
      .busy      (busy_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // Drive one cycle at the falling edge, push its expected outputs, advance the model.
   task automatic do_cycle(input logic r, input logic s, input logic p, input logic st);
      exp_t e;
      reset = r;
      start = s;
      pause = p;
      step  = st;
      lfsr  = 1'($urandom_range(0, 1));
      #1;
      e.mode     = r ? IDLE : m_mode;
      e.seed_en  = !r && (m_mode == SEED);
      e.seed_bit = e.seed_en && lfsr;
      e.tick     = !r && (((m_mode == RUN) && (m_div == TD - 1)) ||
                          (StepEn && (m_mode == PAUSE) && step && !s));
      e.busy     = !r && (m_mode != IDLE);
      e.gen      = m_gen;
      sb_q.push_back(e);
      @(posedge clk);
      if (r) begin
         m_mode = IDLE;
         m_seed = 0;
         m_div  = 0;
         m_gen  = 0;
      end else begin
         if (e.tick) m_gen++;
         case (m_mode)
            IDLE:  if (s) begin m_mode = SEED; m_seed = 0; m_gen = 0; end
            SEED: begin
               if (m_seed == SC - 1) begin
                  m_mode = RUN;
                  m_div  = 0;
               end else begin
                  m_seed++;
               end
            end
            RUN: begin
               m_div = (m_div + 1) % TD;
               if (s) begin m_mode = SEED; m_seed = 0; m_gen = 0; end
               else if (p) m_mode = PAUSE;
            end
            default: begin
               if (s) begin m_mode = SEED; m_seed = 0; m_gen = 0; end
               else if (!p) m_mode = RUN;
            end
         endcase
      end
      @(negedge clk);
   endtask

   // Monitor: pop the expectation for this cycle and compare both instances.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check_eq("mode_a", mode_a, e.mode);
         check_eq("mode_b", mode_b, e.mode);
         check_eq("seed_en", seed_en_a, e.seed_en);
         check_eq("seed_bit", seed_bit_a, e.seed_bit);
         check_eq("tick_a", tick_a, e.tick);
         check_eq("tick_b", tick_b, e.tick);
         check_eq("busy", busy_a, e.busy);
         check_eq("gen_a", gen_a, sat(e.gen, 65535));
         check_eq("gen_b", gen_b, sat(e.gen, 3));
         if (seed_en_a) n_seed_en++;
         if (tick_a) n_tick++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic p_lvl;
      reset = 1'b1; start = 1'b0; pause = 1'b0; lfsr = 1'b0; step = 1'b0;
      m_mode = IDLE; m_seed = 0; m_div = 0; m_gen = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);

      // Reset held, then IDLE ignoring pause/step/lfsr.
      do_cycle(1, 1, 1, 1);
      repeat (3) do_cycle(0, 0, 1, 1);
      check_eq("idle_mode", mode_a, IDLE);

      // Seeding: one start pulse, start/pause toggled during SEED are ignored.
      do_cycle(0, 1, 0, 0);
      n_seed_en = 0;
      for (int i = 0; i < SC; i++) do_cycle(0, i < 3, i % 2, 0);
      check_eq("seed_len", n_seed_en, SC);
      check_eq("run_after_seed", mode_a, RUN);

      // Twenty RUN cycles: ticks on 4,8,...,20.
      n_tick = 0;
      repeat (20) do_cycle(0, 0, 0, 0);
      check_eq("run20_ticks", n_tick, 5);
      check_eq("run20_gen", gen_a, 5);

      // Pause sampled on a tick-due cycle still ticks; hold ten cycles with step pulses.
      repeat (3) do_cycle(0, 0, 0, 0);
      n_tick = 0;
      do_cycle(0, 0, 1, 0);
      check_eq("pause_tick", n_tick, 1);
      check_eq("pause_mode", mode_a, PAUSE);
      n_tick = 0;
      for (int i = 0; i < 10; i++) do_cycle(0, 0, 1, (i == 2) || (i == 5) || (i == 8));
      check_eq("step_ticks", n_tick, StepEn ? 3 : 0);
      check_eq("pause_hold", mode_a, PAUSE);
      n_tick = 0;
      do_cycle(0, 0, 0, 0);
      repeat (3) do_cycle(0, 0, 0, 0);
      check_eq("resume_early", n_tick, 0);
      do_cycle(0, 0, 0, 0);
      check_eq("resume_tick", n_tick, 1);
      check_eq("gen_total", gen_a, StepEn ? 10 : 7);
      check_eq("gen_sat", gen_b, 3);

      // Restart from RUN clears generations; reset mid-SEED returns to IDLE.
      do_cycle(0, 1, 0, 0);
      check_eq("restart_mode", mode_a, SEED);
      check_eq("restart_gen", gen_a, 0);
      repeat (3) do_cycle(0, 0, 0, 0);
      do_cycle(1, 0, 0, 0);
      check_eq("reset_mid_seed", mode_a, IDLE);

      // In PAUSE, start beats a simultaneous step.
      do_cycle(0, 1, 0, 0);
      repeat (SC + 2) do_cycle(0, 0, 0, 0);
      do_cycle(0, 0, 1, 0);
      repeat (2) do_cycle(0, 0, 1, 0);
      do_cycle(0, 1, 1, 1);
      check_eq("start_over_step", mode_a, SEED);

      // Random traffic; step only offered while pause is held.
      p_lvl = 1'b0;
      for (int i = 0; i < 400; i++) begin
         logic r, s, st;
         if ($urandom_range(0, 5) == 0) p_lvl = ~p_lvl;
         r  = ($urandom_range(0, 149) == 0);
         s  = ($urandom_range(0, 23) == 0);
         st = p_lvl && ($urandom_range(0, 2) == 0);
         do_cycle(r, s, p_lvl, st);
      end

      #5;
      check_eq("sb_drain", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter GEN_W, default 16, width of the generation counter (>=2).
REQ-002 SHALL have parameter TICK_DIV, default 4, cycles per RUN tick (>=1).
REQ-003 SHALL have parameter SEED_CYCLES, default 64, length of the seeding phase in cycles (>=1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  level; begin/restart seeding.
REQ-007 SHALL have port pause  input  1  level; hold RUN.
REQ-008 SHALL have port lfsr  input  1  pseudo-random bit from external LFSR.
REQ-009 SHALL have port step  input  1  single-step request; present only when RUN_CTRL_SINGLE_STEP_EN is defined.
REQ-010 SHALL have port mode  output  2  current state: IDLE=00, SEED=01, RUN=10, PAUSE=11.
REQ-011 SHALL have port seed_en  output  1  high in every SEED cycle.
REQ-012 SHALL have port seed_bit  output  1  equals lfsr when seed_en=1, else 0.
REQ-013 SHALL have port tick  output  1  one-cycle generation-advance strobe.
REQ-014 SHALL have port gen_count  output  GEN_W  completed generations.
REQ-015 SHALL have port busy  output  1  high when mode != IDLE.

Function
REQ-016 IDLE: start=1 -> SEED next cycle; otherwise stay; pause, lfsr and step ignored.
REQ-017 Entering SEED SHALL clear gen_count and the seed counter in the same edge.
REQ-018 SEED SHALL last exactly SEED_CYCLES cycles, then -> RUN; start and pause ignored during SEED.
REQ-019 RUN: start=1 -> SEED (start has priority over pause); else pause=1 -> PAUSE; else stay.
REQ-020 Divider SHALL be cleared on entering RUN from SEED and count 0..TICK_DIV-1 in RUN cycles, wrapping to 0.
REQ-021 tick SHALL be combinational: 1 when mode=RUN and divider=TICK_DIV-1; first tick in the TICK_DIV-th RUN cycle; TICK_DIV=1 gives tick every RUN cycle.
REQ-022 A tick due in the cycle pause is first sampled SHALL still be issued.
REQ-023 PAUSE: start=1 -> SEED; else pause=0 -> RUN; divider holds its value and resumes without reset.
REQ-024 gen_count SHALL increment on every edge where tick=1 and saturate at 2^GEN_W-1; tick keeps pulsing at saturation.
REQ-025 seed_en, seed_bit and tick SHALL be 0 in IDLE.

Reset
REQ-026 reset=1 at a clock edge SHALL force mode=IDLE, gen_count=0, divider=0, seed counter=0, overriding all inputs, including mid-SEED or mid-RUN.
REQ-027 While reset is high, outputs SHALL read mode=00, busy=0, seed_en=0, seed_bit=0, tick=0.

Configuration
REQ-028 With RUN_CTRL_SINGLE_STEP_EN defined, step=1 in PAUSE SHALL assert tick that cycle and increment gen_count (saturating), mode stays PAUSE, divider unchanged; step ignored in other states; start in the same cycle wins (no tick).
REQ-029 Without RUN_CTRL_SINGLE_STEP_EN, the step port SHALL not exist and PAUSE SHALL never assert tick.

Structure
REQ-030 Package run_ctrl_pkg SHALL hold the mode_t enum (IDLE, SEED, RUN, PAUSE) with the encodings above.
REQ-031 The divider SHALL be a sub-module tick_divider (parameter N, inputs clk, reset, clr, en; output wrap).

Verification
REQ-032 reset, start=1 one cycle, SEED_CYCLES=8 -> seed_en high exactly 8 cycles, mode 01 then 10.
REQ-033 RUN, TICK_DIV=4, 20 cycles -> tick on RUN cycles 4,8,12,16,20; gen_count=5.
REQ-034 pause=1 on RUN cycle 4 (tick due) -> tick issued, gen_count=1, mode=11 next cycle; release after 10 cycles -> next tick after 4 more RUN cycles.
REQ-035 GEN_W=2, run 6 ticks -> gen_count sticks at 3, tick still pulses.
REQ-036 start=1 in RUN with gen_count=7 -> mode=01, gen_count=0 next cycle; reset mid-SEED -> mode=00 next cycle.
REQ-037 With macro, PAUSE, step pulsed 3 times -> 3 ticks, gen_count+3, mode stays 11; without macro, no tick in PAUSE.
